// File: rtl/mips_pkg.sv
// Shared fetch-sequencer types: state encodings,
// instruction width and the HALT opcode.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch control bundle between debug/hazard/ID logic
// and the fetch sequencer (slave = sequencer side).
interface fetch_sequencer_if;

  logic        i_start;
  logic        i_step_mode;
  logic        i_step;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic [31:0] i_instruction;
  logic [31:0] o_pc;
  logic        o_if_id_we;
  logic        o_if_id_flush;
  logic        o_halted;
  logic        o_fault;
  logic [1:0]  o_state;

  modport slave (
    input  i_start,
    input  i_step_mode,
    input  i_step,
    input  i_stall,
    input  i_branch_taken,
    input  i_branch_target,
    input  i_jump,
    input  i_jump_target,
    input  i_instruction,
    output o_pc,
    output o_if_id_we,
    output o_if_id_flush,
    output o_halted,
    output o_fault,
    output o_state
  );

  modport master (
    output i_start,
    output i_step_mode,
    output i_step,
    output i_stall,
    output i_branch_taken,
    output i_branch_target,
    output i_jump,
    output i_jump_target,
    output i_instruction,
    input  o_pc,
    input  o_if_id_we,
    input  o_if_id_flush,
    input  o_halted,
    input  o_fault,
    input  o_state
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: advance/hold/redirect/stop control.
// FETCH_HALT_DETECT_EN enables in-band HALT opcode detection.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input logic               i_clk,
  input logic               i_reset,
  fetch_sequencer_if.slave  bus
);

  import mips_pkg::*;

  localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fault_q;
  logic        fault_d;
  logic        advance;
  logic        is_halt;
  logic        we;
  logic        flush;
  logic [31:0] nxt;
  logic        unused_instr;

  assign unused_instr = ^bus.i_instruction;

  // State, PC and sticky fault registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next state, next PC and IF/ID controls
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    advance = 1'b0;
    is_halt = 1'b0;
    we      = 1'b0;
    flush   = 1'b0;
    nxt     = pc_q + 32'd4;
`ifdef FETCH_HALT_DETECT_EN
    is_halt = bus.i_instruction[INSTR_W-1 -: 6]
              == HALT_OPCODE;
`else
    is_halt = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_start)
          state_d = bus.i_step_mode ? STEP : RUN;
      end
      RUN, STEP: begin
        state_d = bus.i_step_mode ? STEP : RUN;
        advance = (state_q == RUN) || bus.i_step;
      end
      default: ;
    endcase
    if (advance && !bus.i_stall) begin
      we = 1'b1;
      if (is_halt) begin
        state_d = HALTED;
      end else begin
        if (bus.i_jump) begin
          nxt   = {bus.i_jump_target[31:2], 2'b00};
          flush = 1'b1;
        end else if (bus.i_branch_taken) begin
          nxt   = {bus.i_branch_target[31:2], 2'b00};
          flush = 1'b1;
        end
        if ({1'b0, nxt} >= PC_LIMIT) begin
          fault_d = 1'b1;
          state_d = HALTED;
        end else begin
          pc_d = nxt;
        end
      end
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_if_id_we    = we;
  assign bus.o_if_id_flush = flush;
  assign bus.o_halted      = (state_q == HALTED);
  assign bus.o_fault       = fault_q;
  assign bus.o_state       = state_q;

endmodule
